// File: rtl/win_scanner.sv
// Sequential win detector for an N x N noughts-and-crosses board, one line per clock.
// Optional macro WIN_SCANNER_EARLY_EXIT_EN: finish the scan right after the first winning line.
module win_scanner #(
    parameter  int N  = 3,
    localparam int LW = $clog2(2*N+2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [N*N-1:0]  board_x,
    input  logic [N*N-1:0]  board_o,
    output logic            busy,
    output logic            done,
    output logic            win_x,
    output logic            win_o,
    output logic [LW-1:0]   win_line,
    output logic            draw,
    output logic            err
);

    localparam int L = 2*N + 2;
    localparam int C = N*N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [C-1:0]    snap_x;
    logic [C-1:0]    snap_o;
    logic [LW-1:0]   idx;

    logic            acc_x;
    logic            acc_o;
    logic            acc_found;
    logic [LW-1:0]   acc_line;

    logic [C-1:0]    line_mask;
    logic            cur_x;
    logic            cur_o;
    logic            last_line;
    logic            early;
    logic            scan_end;

    logic            fin_x;
    logic            fin_o;
    logic [LW-1:0]   fin_line;
    logic            fin_err;
    logic            fin_full;

    // Cell mask of the line currently addressed by idx.
    always_comb begin
        line_mask = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if ((int'(idx) == r) ||
                    (int'(idx) == N + c) ||
                    ((int'(idx) == 2*N) && (r == c)) ||
                    ((int'(idx) == 2*N + 1) && (r + c == N - 1))) begin
                    line_mask[r*N + c] = 1'b1;
                end
            end
        end
    end

    assign cur_x     = ((snap_x & line_mask) == line_mask);
    assign cur_o     = ((snap_o & line_mask) == line_mask);
    assign last_line = (idx == LW'(L - 1));

`ifdef WIN_SCANNER_EARLY_EXIT_EN
    assign early = cur_x | cur_o;
`else
    assign early = 1'b0;
`endif

    assign scan_end = last_line | early;

    // Final results include the line being evaluated in the last SCAN cycle.
    always_comb begin
        fin_x    = acc_x | cur_x;
        fin_o    = acc_o | cur_o;
        fin_line = '0;
        if (acc_found) begin
            fin_line = acc_line;
        end else if (cur_x | cur_o) begin
            fin_line = idx;
        end
        fin_err  = |(snap_x & snap_o);
        fin_full = &(snap_x | snap_o);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (scan_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SCAN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Snapshot, line index, accumulators and published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_x    <= '0;
            snap_o    <= '0;
            idx       <= '0;
            acc_x     <= 1'b0;
            acc_o     <= 1'b0;
            acc_found <= 1'b0;
            acc_line  <= '0;
            win_x     <= 1'b0;
            win_o     <= 1'b0;
            win_line  <= '0;
            draw      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_x    <= board_x;
                        snap_o    <= board_o;
                        idx       <= '0;
                        acc_x     <= 1'b0;
                        acc_o     <= 1'b0;
                        acc_found <= 1'b0;
                        acc_line  <= '0;
                        win_x     <= 1'b0;
                        win_o     <= 1'b0;
                        win_line  <= '0;
                        draw      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                SCAN: begin
                    acc_x <= fin_x;
                    acc_o <= fin_o;
                    if ((cur_x | cur_o) && !acc_found) begin
                        acc_found <= 1'b1;
                        acc_line  <= idx;
                    end
                    if (scan_end) begin
                        // An illegal board suppresses every other result.
                        win_x    <= fin_x & ~fin_err;
                        win_o    <= fin_o & ~fin_err;
                        win_line <= fin_err ? '0 : fin_line;
                        draw     <= fin_full & ~fin_err & ~(fin_x | fin_o);
                        err      <= fin_err;
                    end else begin
                        idx <= idx + LW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_win_scanner.sv
// Directed bench for win_scanner (N=3): vector table plus multi-cycle sequences
// for mid-scan start/board changes and mid-scan reset.
module tb_win_scanner;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [8:0] board_x;
    logic [8:0] board_o;
    logic       busy;
    logic       done;
    logic       win_x;
    logic       win_o;
    logic [2:0] win_line;
    logic       draw;
    logic       err;

    int checks;
    int errors;

    win_scanner #(.N(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .board_x  (board_x),
        .board_o  (board_o),
        .busy     (busy),
        .done     (done),
        .win_x    (win_x),
        .win_o    (win_o),
        .win_line (win_line),
        .draw     (draw),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] x;
        logic [8:0] o;
        logic       wx;
        logic       wo;
        logic       wo_early;
        logic [2:0] line;
        logic       draw;
        logic       err;
        int         first;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int first);
`ifdef WIN_SCANNER_EARLY_EXIT_EN
        return (first >= 0) ? first + 2 : 9;
`else
        return 9 + (first - first);
`endif
    endfunction

    // Launch a scan and wait (bounded) for done; lat counts cycles after acceptance.
    task automatic scan(input logic [8:0] x, input logic [8:0] o,
                        output int lat, output int bcnt);
        @(negedge clk);
        board_x = x;
        board_o = o;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        logic exp_o;

        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        board_x = '0;
        board_o = '0;

        //           x             o             wx    wo    wo_e  line  draw  err   first
        vecs[0]  = '{9'b000000111, 9'b000000000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 0};
        vecs[1]  = '{9'b000000011, 9'b001010100, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 7};
        vecs[2]  = '{9'b110001101, 9'b001110010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, -1};
        vecs[3]  = '{9'b000000001, 9'b000000001, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, -1};
        vecs[4]  = '{9'b000000101, 9'b010010010, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 4};
        vecs[5]  = '{9'b100010001, 9'b000000110, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 6};
        vecs[6]  = '{9'b000000000, 9'b000000000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, -1};
        vecs[7]  = '{9'b000000111, 9'b111000000, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0};
        vecs[8]  = '{9'b111000000, 9'b000000011, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 2};
        vecs[9]  = '{9'b000000111, 9'b000000100, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 0};
        vecs[10] = '{9'b001100111, 9'b110011000, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 0};
        vecs[11] = '{9'b001010100, 9'b000000000, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 7};

        // Reset state
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_win_x", int'(win_x), 0);
        check("reset_win_o", int'(win_o), 0);
        check("reset_line", int'(win_line), 0);
        check("reset_draw", int'(draw), 0);
        check("reset_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
`ifdef WIN_SCANNER_EARLY_EXIT_EN
            exp_o = vecs[i].wo_early;
`else
            exp_o = vecs[i].wo;
`endif
            scan(vecs[i].x, vecs[i].o, lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, exp_latency(vecs[i].first));
            check($sformatf("v%0d_busy_cycles", i), bcnt, exp_latency(vecs[i].first) - 1);
            check($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
            check($sformatf("v%0d_win_x", i), int'(win_x), int'(vecs[i].wx));
            check($sformatf("v%0d_win_o", i), int'(win_o), int'(exp_o));
            check($sformatf("v%0d_line", i), int'(win_line), int'(vecs[i].line));
            check($sformatf("v%0d_draw", i), int'(draw), int'(vecs[i].draw));
            check($sformatf("v%0d_err", i), int'(err), int'(vecs[i].err));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), int'(done), 0);
            check($sformatf("v%0d_hold_line", i), int'(win_line), int'(vecs[i].line));
            check($sformatf("v%0d_hold_win_x", i), int'(win_x), int'(vecs[i].wx));
        end

        // Board change and second start mid-scan are ignored; start in DONE is ignored.
        @(negedge clk);
        board_x = 9'b001010100;
        board_o = 9'b000000000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (lat == 3) begin
                board_x = 9'b000000000;
                board_o = 9'b000000111;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("midscan_latency", lat, 9);
        check("midscan_win_x", int'(win_x), 1);
        check("midscan_win_o", int'(win_o), 0);
        check("midscan_line", int'(win_line), 7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_busy", int'(busy), 0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("no_queued_scan", dcnt, 0);

        // Reset in the middle of a scan aborts it immediately.
        @(negedge clk);
        board_x = 9'b001010100;
        board_o = 9'b000000000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_win_x", int'(win_x), 0);
        check("abort_line", int'(win_line), 0);
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        scan(vecs[1].x, vecs[1].o, lat, bcnt);
        check("after_reset_latency", lat, exp_latency(vecs[1].first));
        check("after_reset_win_o", int'(win_o), 1);
        check("after_reset_win_x", int'(win_x), 0);
        check("after_reset_line", int'(win_line), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
